// File: rtl/pci_rr_arbiter.sv
// Round-robin central arbiter for the shared PCI-style bus.
// Tracks ownership from frame_n/irdy_n, with burst latency limit and start timeout.
module pci_rr_arbiter #(
    parameter int N_REQ    = 5,
    parameter int LAT_CYC  = 8,
    parameter int START_TO = 16,
    parameter int PARK_EN  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_n,
    input  logic             frame_n,
    input  logic             irdy_n,
    output logic [N_REQ-1:0] gnt_n,
    output logic [2:0]       owner,
    output logic             bus_busy,
    output logic             timeout
);

    localparam int LW = $clog2(LAT_CYC) + 1;
    localparam int SW = $clog2(START_TO) + 1;
    localparam logic [N_REQ-1:0] NONE = '1;
    localparam logic [N_REQ-1:0] ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BUSY,
        S_TURN
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_n_q, gnt_n_d;
    logic [2:0]       owner_q, owner_d;
    logic [2:0]       last_q,  last_d;
    logic             prior_q, prior_d;
    logic             busy_q,  busy_d;
    logic             to_q,    to_d;
    logic [SW-1:0]    st_q,    st_d;
    logic [LW-1:0]    lat_q,   lat_d;

    logic             any_req;
    logic [2:0]       win;
    logic [N_REQ-1:0] own_oh;
    logic             others;
    logic             owner_req;
    logic [LW-1:0]    lat_inc;
    int               idx;

    // First requester found scanning upward from the slot after last.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!any_req && !req_n[3'(idx)]) begin
                any_req = 1'b1;
                win     = 3'(idx);
            end
        end
    end

    always_comb begin
        own_oh  = ONE << owner_q;
        others  = |(~req_n & ~own_oh);
        owner_req = !req_n[owner_q];
        lat_inc = lat_q;
        if (lat_q < LW'(LAT_CYC)) begin
            lat_inc = lat_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_n_d = gnt_n_q;
        owner_d = owner_q;
        last_d  = last_q;
        prior_d = prior_q;
        st_d    = st_q;
        lat_d   = lat_q;
        to_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_n_q != NONE && !frame_n) begin
                    state_d = S_BUSY;
                    owner_d = last_q;
                    lat_d   = '0;
                end else if (any_req) begin
                    state_d = S_WAIT;
                    gnt_n_d = ~(ONE << win);
                    owner_d = win;
                    last_d  = win;
                    prior_d = 1'b1;
                    st_d    = '0;
                end else if (PARK_EN != 0 && prior_q) begin
                    gnt_n_d = ~(ONE << last_q);
                end else begin
                    gnt_n_d = NONE;
                end
            end
            S_WAIT: begin
                if (!frame_n) begin
                    state_d = S_BUSY;
                    lat_d   = '0;
                end else if (!owner_req) begin
                    state_d = S_IDLE;
                    gnt_n_d = NONE;
                end else if (st_q == SW'(START_TO - 1)) begin
                    // last keeps the stalled master, so it goes to the back
                    state_d = S_IDLE;
                    gnt_n_d = NONE;
                    to_d    = 1'b1;
                end else begin
                    st_d = st_q + 1'b1;
                end
            end
            S_BUSY: begin
                lat_d = lat_inc;
                if (frame_n && irdy_n) begin
                    state_d = S_TURN;
                    gnt_n_d = NONE;
                end else if (!owner_req ||
                             (lat_inc >= LW'(LAT_CYC) && others)) begin
                    gnt_n_d = NONE;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
                gnt_n_d = NONE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_n_d = NONE;
            end
        endcase
        busy_d = (state_d == S_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_n_q <= NONE;
            owner_q <= '0;
            last_q  <= 3'(N_REQ - 1);
            prior_q <= 1'b0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            st_q    <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_n_q <= gnt_n_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            prior_q <= prior_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            st_q    <= st_d;
            lat_q   <= lat_d;
        end
    end

    assign gnt_n    = gnt_n_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_pci_rr_arbiter;

    localparam int N   = 5;
    localparam int LAT = 8;
    localparam int STO = 16;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_BUSY = 2;
    localparam int P_TURN = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req_n = '1;
    logic       frame_n = 1'b1;
    logic       irdy_n = 1'b1;
    logic [4:0] gnt_n;
    logic [2:0] owner;
    logic       bus_busy;
    logic       timeout;

    int n_chk = 0;
    int n_fail = 0;

    int m_ph, m_g, m_own, m_last, m_wait, m_lat;
    bit m_prior, m_to;

    pci_rr_arbiter #(
        .N_REQ(N), .LAT_CYC(LAT), .START_TO(STO), .PARK_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_n(req_n),
        .frame_n(frame_n), .irdy_n(irdy_n), .gnt_n(gnt_n),
        .owner(owner), .bus_busy(bus_busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(logic [4:0] r, int lst);
        for (int o = 1; o <= N; o++) begin
            if (!r[(lst + o) % N]) return (lst + o) % N;
        end
        return -1;
    endfunction

    function automatic logic [4:0] gvec(int g);
        logic [4:0] v;
        v = '1;
        if (g >= 0) v[g] = 1'b0;
        return v;
    endfunction

    function automatic void m_reset();
        m_ph = P_IDLE; m_g = -1; m_own = 0; m_last = N - 1;
        m_prior = 0; m_wait = 0; m_lat = 0; m_to = 0;
    endfunction

    function automatic void m_step(logic [4:0] r, logic f, logic i);
        int w;
        bit oth;
        m_to = 0;
        case (m_ph)
            P_IDLE: begin
                w = pick(r, m_last);
                if (m_g >= 0 && !f) begin
                    m_ph = P_BUSY; m_own = m_last; m_lat = 0;
                end else if (w >= 0) begin
                    m_g = w; m_own = w; m_last = w; m_prior = 1;
                    m_ph = P_WAIT; m_wait = 0;
                end else begin
                    m_g = m_prior ? m_last : -1;
                end
            end
            P_WAIT: begin
                m_wait++;
                if (!f) begin
                    m_ph = P_BUSY; m_lat = 0;
                end else if (r[m_own]) begin
                    m_g = -1; m_ph = P_IDLE;
                end else if (m_wait == STO) begin
                    m_g = -1; m_to = 1; m_ph = P_IDLE;
                end
            end
            P_BUSY: begin
                m_lat = (m_lat < LAT) ? m_lat + 1 : LAT;
                oth = 0;
                for (int o = 0; o < N; o++)
                    if (o != m_own && !r[o]) oth = 1;
                if (f && i) begin
                    m_ph = P_TURN; m_g = -1;
                end else if (r[m_own] || (m_lat >= LAT && oth)) begin
                    m_g = -1;
                end
            end
            default: begin
                m_g = -1; m_ph = P_IDLE;
            end
        endcase
    endfunction

    task automatic cyc(input logic [4:0] r, input logic f, input logic i);
        req_n = r; frame_n = f; irdy_n = i;
        @(posedge clk); #1;
        m_step(r, f, i);
    endtask

    task automatic do_reset();
        req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (gnt_n !== 5'h1f) begin
            n_fail++; $display("FAIL reset_gnt got %b want 11111", gnt_n);
        end
        n_chk++;
        if (owner !== 3'd0 || bus_busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got o=%0d b=%b t=%b want 0 0 0",
                     owner, bus_busy, timeout);
        end
        cyc(5'h1f, 1, 1);
        n_chk++;
        if (gnt_n !== 5'h1f) begin
            n_fail++; $display("FAIL noprior_park got %b want 11111", gnt_n);
        end
    endtask

    task automatic test_basic();
        cyc(5'b11110, 1, 1);
        n_chk++;
        if (gnt_n !== 5'b11110) begin
            n_fail++; $display("FAIL basic_gnt got %b want 11110", gnt_n);
        end
        cyc(5'b11110, 0, 0);
        n_chk++;
        if (bus_busy !== 1'b1 || owner !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_busy got b=%b o=%0d want 1 0", bus_busy, owner);
        end
        cyc(5'b11110, 0, 0);
        cyc(5'b11110, 0, 0);
        n_chk++;
        if (bus_busy !== 1'b1 || gnt_n !== 5'b11110) begin
            n_fail++;
            $display("FAIL basic_hold got b=%b g=%b want 1 11110", bus_busy, gnt_n);
        end
        cyc(5'h1f, 1, 1);
        n_chk++;
        if (bus_busy !== 1'b0 || gnt_n !== 5'h1f) begin
            n_fail++;
            $display("FAIL basic_turn got b=%b g=%b want 0 11111", bus_busy, gnt_n);
        end
        cyc(5'h1f, 1, 1);
        cyc(5'h1f, 1, 1);
        n_chk++;
        if (gnt_n !== 5'b11110) begin
            n_fail++; $display("FAIL basic_park got %b want 11110", gnt_n);
        end
    endtask

    task automatic test_rotation();
        logic [4:0] ev;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            ev = '1;
            ev[k % 3] = 1'b0;
            cyc(5'b11000, 1, 1);
            n_chk++;
            if (gnt_n !== ev) begin
                n_fail++; $display("FAIL rot_gnt%0d got %b want %b", k, gnt_n, ev);
            end
            cyc(5'b11000, 0, 0);
            cyc(5'b11000, 0, 0);
            cyc(5'b11000, 1, 1);
            n_chk++;
            if (gnt_n !== 5'h1f || bus_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rot_turn%0d got %b b=%b want 11111 0", k, gnt_n, bus_busy);
            end
            cyc(5'b11000, 1, 1);
        end
    endtask

    task automatic test_park();
        cyc(5'b10111, 1, 1);
        cyc(5'b10111, 0, 0);
        cyc(5'h1f, 0, 0);
        cyc(5'h1f, 1, 1);
        cyc(5'h1f, 1, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(5'h1f, 1, 1);
            n_chk++;
            if (gnt_n !== 5'b10111) begin
                n_fail++; $display("FAIL park%0d got %b want 10111", k, gnt_n);
            end
        end
        cyc(5'h1f, 0, 1);
        n_chk++;
        if (bus_busy !== 1'b1 || owner !== 3'd3) begin
            n_fail++;
            $display("FAIL park_busy got b=%b o=%0d want 1 3", bus_busy, owner);
        end
        cyc(5'h1f, 1, 1);
        cyc(5'h1f, 1, 1);
    endtask

    task automatic test_latency();
        logic [4:0] r, ev;
        cyc(5'b11101, 1, 1);
        n_chk++;
        if (gnt_n !== 5'b11101) begin
            n_fail++; $display("FAIL lat_gnt got %b want 11101", gnt_n);
        end
        cyc(5'b11101, 0, 0);
        for (int j = 1; j < 20; j++) begin
            r  = (j >= 2) ? 5'b01101 : 5'b11101;
            ev = (j >= LAT) ? 5'h1f : 5'b11101;
            cyc(r, 0, 0);
            n_chk++;
            if (gnt_n !== ev || bus_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL lat_c%0d got %b b=%b want %b 1", j, gnt_n, bus_busy, ev);
            end
        end
        cyc(5'b01101, 1, 1);
        cyc(5'b01101, 1, 1);
        n_chk++;
        if (gnt_n !== 5'h1f) begin
            n_fail++; $display("FAIL lat_idle got %b want 11111", gnt_n);
        end
        cyc(5'b01101, 1, 1);
        n_chk++;
        if (gnt_n !== 5'b01111 || owner !== 3'd4) begin
            n_fail++;
            $display("FAIL lat_next got %b o=%0d want 01111 4", gnt_n, owner);
        end
        cyc(5'h1f, 1, 1);
    endtask

    task automatic test_timeout();
        logic [4:0] ev;
        do_reset();
        cyc(5'b10011, 1, 1);
        n_chk++;
        if (gnt_n !== 5'b11011 || owner !== 3'd2) begin
            n_fail++;
            $display("FAIL to_gnt got %b o=%0d want 11011 2", gnt_n, owner);
        end
        for (int j = 1; j <= STO; j++) begin
            cyc(5'b10011, 1, 1);
            ev = (j == STO) ? 5'h1f : 5'b11011;
            n_chk++;
            if (gnt_n !== ev || timeout !== (j == STO)) begin
                n_fail++;
                $display("FAIL to_c%0d got %b t=%b want %b %b",
                         j, gnt_n, timeout, ev, (j == STO));
            end
        end
        cyc(5'b10011, 1, 1);
        n_chk++;
        if (gnt_n !== 5'b10111 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_next got %b t=%b want 10111 0", gnt_n, timeout);
        end
    endtask

    task automatic test_reset_busy();
        cyc(5'b10111, 0, 0);
        n_chk++;
        if (bus_busy !== 1'b1) begin
            n_fail++; $display("FAIL rb_busy got %b want 1", bus_busy);
        end
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        n_chk++;
        if (gnt_n !== 5'h1f || bus_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_async got %b b=%b want 11111 0", gnt_n, bus_busy);
        end
        req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(5'b11101, 1, 1);
        n_chk++;
        if (gnt_n !== 5'b11101) begin
            n_fail++; $display("FAIL rb_regrant got %b want 11101", gnt_n);
        end
    endtask

    task automatic test_random();
        logic [4:0] r;
        logic f, i;
        int burst;
        do_reset();
        r = '1;
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                r = 5'($urandom) | 5'($urandom);
            if (burst == 0 && $urandom_range(0, 5) == 0)
                burst = $urandom_range(1, 12);
            f = (burst == 0);
            i = (burst == 0) ? ($urandom_range(0, 7) != 0) : 1'($urandom);
            if (burst > 0) burst--;
            cyc(r, f, i);
            n_chk++;
            if (gnt_n !== gvec(m_g) || owner !== 3'(m_own) ||
                bus_busy !== (m_ph == P_BUSY) || timeout !== m_to) begin
                n_fail++;
                $display("FAIL rand_c%0d got g=%b o=%0d b=%b t=%b want g=%b o=%0d b=%b t=%b",
                         c, gnt_n, owner, bus_busy, timeout,
                         gvec(m_g), m_own, (m_ph == P_BUSY), m_to);
            end
            n_chk++;
            if ($countones(~gnt_n) > 1) begin
                n_fail++; $display("FAIL rand_onehot%0d got %b want <=1 low", c, gnt_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_park();
        test_latency();
        test_timeout();
        test_reset_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pci_rr_arbiter.md
# pci_rr_arbiter

Central arbiter for the shared PCI-style bus (AD/CBE/iframe/iready/tready/devsel) used by the `device` instances. It replaces fixed-priority granting with rotating-priority (round-robin) selection. It tracks bus ownership from the `frame_n`/`irdy_n` lines and enforces a latency limit on long bursts. A start timeout reclaims grants from masters that never begin a transaction.

## Interface
- N_REQ, 5, number of requesters (index 0..N_REQ-1).
- LAT_CYC, 8, BUSY cycles after which the grant is withdrawn if another requester is waiting.
- START_TO, 16, WAIT_START cycles allowed before an unused grant is revoked.
- PARK_EN, 1, when 1, the last owner stays granted while no requests are pending.
- clk  in  1  bus clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_n  in  N_REQ  bus requests, active low, one per device.
- frame_n  in  1  bus iframe, active low.
- irdy_n  in  1  bus iready, active low.
- gnt_n  out  N_REQ  grants, active low, registered; at most one bit low at any time.
- owner  out  3  index of the currently granted/owning master; valid when `bus_busy` or any grant is low.
- bus_busy  out  1  high in BUSY state.
- timeout  out  1  one-cycle pulse when a start timeout revokes a grant.

## Operation
- States: IDLE, WAIT_START, BUSY, TURN. Reset values: state=IDLE, gnt_n=all 1, owner=0, last=N_REQ-1, bus_busy=0, timeout=0, counters=0.
- Winner selection uses rotating priority. The search starts at index (last+1) mod N_REQ and takes the first index with req_n low. `last` updates to the winner when a grant is issued.
- IDLE:
  - Any request → grant winner, go to WAIT_START, clear the start counter.
  - No request and PARK_EN=1 with a prior owner → gnt_n parked on `last`, stay in IDLE.
  - No request and PARK_EN=0 → gnt_n=all 1.
  - frame_n low seen while parked → BUSY, owner=last.
- WAIT_START:
  - frame_n low → BUSY, clear the latency counter.
  - Owner releases req_n before frame_n → drop grant, go to IDLE.
  - Start counter reaches START_TO-1 → drop grant, pulse timeout, go to IDLE; `last` stays at the owner, so that master loses its turn.
- BUSY:
  - Latency counter increments each cycle and saturates at LAT_CYC.
  - Grant is held while owner req_n is low.
  - Grant is removed (gnt_n all 1) when owner req_n goes high, or when counter ≥ LAT_CYC and any other req_n is low.
  - The arbiter never drives the bus; the owner finishes its current data phase.
  - frame_n high and irdy_n high → TURN.
- TURN: gnt_n all 1 for exactly one cycle, then IDLE. This is the mandatory turnaround, so no back-to-back grants without an idle cycle.
- Simultaneous requests resolve only by rotating priority. A new request arriving during BUSY waits; it never preempts before LAT_CYC.
- Reset mid-operation: all grants deassert immediately (asynchronous) and the state machine returns to IDLE with reset values.
- Counter widths: `$clog2` of the parameter + 1. The owner field is 3 bits for N_REQ ≤ 8.

## Timing
- Inputs are sampled at posedge. gnt_n/owner/bus_busy/timeout are registered.
- Request-to-grant latency:
  - Request low before edge k in IDLE → gnt_n low after edge k (1 cycle).
  - From TURN → 2 cycles minimum.
- frame_n low sampled at edge k → bus_busy high after edge k.
- Bus idle (frame_n=irdy_n=1) sampled at edge k in BUSY → TURN after k, IDLE after k+1, next grant after k+2.
- Latency withdraw: BUSY entered at edge k, LAT_CYC=8, competitor waiting → gnt_n all 1 after edge k+8.
- Start timeout: grant at edge k, no frame_n → timeout pulse and grant drop after edge k+START_TO.

## Test plan
- Reset, then req_n=5'b11110 → gnt_n=5'b11110 one cycle later; frame_n low for 3 cycles → bus_busy=1, owner=0; frame_n/irdy_n high → TURN, then IDLE parked on 0.
- req_n=5'b11000 held with each master doing a 2-cycle frame → grant order 0,1,2,0,1,2 with one TURN cycle between each.
- PARK_EN=1, all req_n high after master 3 finishes → gnt_n=5'b10111 held; frame_n low → BUSY, owner=3 without a re-request.
- Master 1 holds frame_n low for 20 cycles, master 4 requests at cycle 2 → gnt_n[1] goes high 8 cycles after BUSY entry; gnt_n[4] goes low only after bus idle + TURN.
- Master 2 granted and never asserts frame_n → timeout pulse at START_TO=16 cycles; master 3 (also requesting) granted 1 cycle later.
- rst_n low during BUSY → gnt_n=5'b11111 and bus_busy=0 asynchronously; after release, req_n=5'b11101 → grant 1 one cycle later.
